spm_boot_loader: RTL

- Byte-stream boot loader directly upstream of the scratchpad data memory write port.
- Accepts a framed byte stream (from the UART receiver) and assembles little-endian 32-bit words.
- Writes each word into the scratchpad through its wrAddress/wrData/wrEnable_0..3 port.
- Holds the core in reset until the image is loaded, then releases it.

---
 rtl/spm_boot_loader_pkg.sv | 15 +
 rtl/spm_boot_loader_if.sv | 27 ++
 rtl/spm_boot_loader_assembler.sv | 35 +++
 rtl/spm_boot_loader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/spm_boot_loader_pkg.sv
// Shared types and constants for the scratchpad boot loader.
package spm_boot_pkg;

    typedef enum logic [2:0] {
        S_ADDR,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERROR
    } boot_state_t;

    localparam int unsigned HDR_BYTES = 4;
    localparam int unsigned LANES     = 4;

endpackage

// File: rtl/spm_boot_loader_if.sv
// Byte-stream receive handshake plus scratchpad write port of the boot loader.
interface spm_boot_loader_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic [7:0]        io_rxData;
    logic              io_rxValid;
    logic              io_rxReady;
    logic [ADDR_W-1:0] io_wrAddress;
    logic [31:0]       io_wrData;
    logic              io_wrEnable_0;
    logic              io_wrEnable_1;
    logic              io_wrEnable_2;
    logic              io_wrEnable_3;

    // master: UART byte source and scratchpad write sink
    modport master (
        output io_rxData, io_rxValid,
        input  io_rxReady, io_wrAddress, io_wrData,
        input  io_wrEnable_0, io_wrEnable_1, io_wrEnable_2, io_wrEnable_3
    );

    modport slave (
        input  io_rxData, io_rxValid,
        output io_rxReady, io_wrAddress, io_wrData,
        output io_wrEnable_0, io_wrEnable_1, io_wrEnable_2, io_wrEnable_3
    );
endinterface

// File: rtl/spm_boot_loader_assembler.sv
// Little-endian word assembler: byte n of a group lands in lane n.
module le_word_assembler
    import spm_boot_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);
    logic [1:0]  cnt;
    logic [31:0] held;

    // word already includes the byte being accepted, so it is usable with word_complete
    always_comb begin
        word = held;
        word[{cnt, 3'b000} +: 8] = byte_data;
    end

    assign word_complete = byte_valid && (cnt == 2'(LANES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            held <= '0;
        end else if (clear) begin
            cnt  <= '0;
        end else if (byte_valid) begin
            held <= word;
            cnt  <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/spm_boot_loader.sv
// Boot loader: header (base, count) then data words into scratchpad; holds CPU in reset until loaded.
module spm_boot_loader
    import spm_boot_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    spm_boot_loader_if.slave    bus,
    input  logic                io_restart,
    output logic                io_cpuReset,
    output logic                io_done,
    output logic                io_error
);
    localparam int unsigned EW = ADDR_W + 2;
    localparam logic [EW-1:0] MEM_BYTES = EW'(MEM_WORDS) << 2;

    boot_state_t       state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] wr_address;
    logic [31:0]       wr_data;
    logic              wr_en;
    logic              rx_ready;
    logic              cpu_reset;
    logic              done;
    logic              error;

    logic              accept;
    logic [31:0]       word;
    logic              word_complete;
    logic [EW-1:0]     base_ext;
    logic [EW-1:0]     span;
    logic              out_of_range;

    assign accept = bus.io_rxValid && rx_ready && !io_restart;

    le_word_assembler u_asm (
        .clock         (clock),
        .reset         (reset),
        .clear         (io_restart),
        .byte_valid    (accept),
        .byte_data     (bus.io_rxData),
        .word          (word),
        .word_complete (word_complete)
    );

    assign base_ext     = EW'(cur_addr);
    assign span         = EW'(ADDR_W'(word)) << 2;
    assign out_of_range = (base_ext >= MEM_BYTES) || ((base_ext + span) > MEM_BYTES);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_ADDR;
            cur_addr   <= '0;
            remaining  <= '0;
            wr_address <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            rx_ready   <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (io_restart) begin
                state     <= S_ADDR;
                rx_ready  <= 1'b1;
                cpu_reset <= 1'b1;
                done      <= 1'b0;
                error     <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        rx_ready <= 1'b1;
                        if (word_complete) begin
                            cur_addr <= ADDR_W'(word) & ~ADDR_W'(3);
                            state    <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (word_complete) begin
                            remaining <= ADDR_W'(word);
                            if (word == '0) begin
                                state     <= S_DONE;
                                rx_ready  <= 1'b0;
                                done      <= 1'b1;
                                cpu_reset <= 1'b0;
                            end else if (out_of_range) begin
                                state    <= S_ERROR;
                                rx_ready <= 1'b0;
                                error    <= 1'b1;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (word_complete) begin
                            wr_en      <= 1'b1;
                            wr_data    <= word;
                            wr_address <= cur_addr;
                            cur_addr   <= cur_addr + ADDR_W'(4);
                            remaining  <= remaining - ADDR_W'(1);
                            if (remaining == ADDR_W'(1)) rx_ready <= 1'b0;
                        end else if (wr_en && remaining == '0) begin
                            // the last word's write cycle is in progress; release the core after it
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end
                    end
                    default: rx_ready <= 1'b0;
                endcase
            end
        end
    end

    assign bus.io_rxReady    = rx_ready;
    assign bus.io_wrAddress  = wr_address;
    assign bus.io_wrData     = wr_data;
    assign bus.io_wrEnable_0 = wr_en;
    assign bus.io_wrEnable_1 = wr_en;
    assign bus.io_wrEnable_2 = wr_en;
    assign bus.io_wrEnable_3 = wr_en;
    assign io_cpuReset       = cpu_reset;
    assign io_done           = done;
    assign io_error          = error;
endmodule
